// File: rtl/shiftrow_fwd_stage_if.sv
// shiftrow_fwd_stage_if: 128-bit AES state stream with valid/ready handshake
interface shiftrow_fwd_stage_if;
  logic [127:0] data;
  logic         valid;
  logic         ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/shiftrow_fwd_stage.sv
// shiftrow_fwd_stage: buffered AES ShiftRows stage, 2-entry skid FIFO; SHIFTROW_INV_EN adds per-push inverse select
module shiftrow_fwd_stage (
  input  logic                        clk,
  input  logic                        rst_n,
  shiftrow_fwd_stage_if.slave         in_if,
  shiftrow_fwd_stage_if.master        out_if,
  output logic [1:0]                  count
`ifdef SHIFTROW_INV_EN
  ,
  input  logic                        inv
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t       state, state_next;
  logic [127:0] mem [2];
  logic [127:0] shifted;
  logic         wp, rp, rdy, push, pop, inv_sel;
`ifdef SHIFTROW_INV_EN
  assign inv_sel = inv;
`else
  assign inv_sel = 1'b0;
`endif
  function automatic logic [127:0] shift_rows(input logic [127:0] d, input logic inv_map);
    logic [127:0] s;
    s = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[127-8*(r+4*c) -: 8] = d[127-8*(r+4*(inv_map ? (c-r+4)%4 : (c+r)%4)) -: 8];
    return s;
  endfunction
  assign shifted      = shift_rows(in_if.data, inv_sel);
  assign push         = in_if.valid & rdy;
  assign pop          = out_if.valid & out_if.ready;
  assign in_if.ready  = rdy;
  assign out_if.valid = state != EMPTY;
  assign out_if.data  = mem[rp];
  assign count        = state;
  always_comb begin
    state_next = state;
    state_next = (push & ~pop) ? ((state == EMPTY) ? ONE : FULL)
               : (pop & ~push) ? ((state == FULL) ? ONE : EMPTY)
               : state;
  end
  // ready is registered from the next occupancy so it never depends on downstream ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      rdy    <= 1'b0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      state <= state_next;
      rdy   <= state_next != FULL;
      if (push) begin
        mem[wp] <= shifted;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
    end
  end
endmodule

// File: tb/tb_shiftrow_fwd_stage.sv
// tb_shiftrow_fwd_stage: directed checks of map, backpressure, streaming and reset
module tb_shiftrow_fwd_stage;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] count;
  int         tests = 0;
  int         fails = 0;
  localparam logic [127:0] A    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SR_A = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] B    = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] SR_B = 128'h10151a1f14191e13181d12171c11161b;
  localparam logic [127:0] C    = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] SR_C = 128'hffaa5500bb6611cc7722dd8833ee9944;
  shiftrow_fwd_stage_if in_if();
  shiftrow_fwd_stage_if out_if();
`ifdef SHIFTROW_INV_EN
  logic inv = 1'b0;
  localparam logic [127:0] ISR_A = 128'h000d0a0704010e0b0805020f0c090603;
  shiftrow_fwd_stage dut (.clk(clk), .rst_n(rst_n), .in_if(in_if), .out_if(out_if), .count(count), .inv(inv));
`else
  shiftrow_fwd_stage dut (.clk(clk), .rst_n(rst_n), .in_if(in_if), .out_if(out_if), .count(count));
`endif
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    logic [127:0] y;
    rst_n = 1'b0;
    in_if.valid = 1'b0;
    in_if.data = '0;
    out_if.ready = 1'b0;
    @(negedge clk);
    check("rst_valid", 128'(out_if.valid), 128'd0);
    check("rst_ready", 128'(in_if.ready), 128'd0);
    check("rst_count", 128'(count), 128'd0);
    check("rst_dout", out_if.data, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 128'(in_if.ready), 128'd1);
    check("rel_count", 128'(count), 128'd0);
    // single transfer through the map
    in_if.valid = 1'b1; in_if.data = A; out_if.ready = 1'b1;
    @(negedge clk);
    check("map_dout", out_if.data, SR_A);
    check("map_valid", 128'(out_if.valid), 128'd1);
    check("map_count", 128'(count), 128'd1);
    in_if.valid = 1'b0;
    @(negedge clk);
    check("map_valid_drop", 128'(out_if.valid), 128'd0);
    check("map_count_drop", 128'(count), 128'd0);
    // backpressure: A, B fill the buffer, C must wait
    out_if.ready = 1'b0; in_if.valid = 1'b1; in_if.data = A;
    @(negedge clk);
    check("bp_ready_one", 128'(in_if.ready), 128'd1);
    in_if.data = B;
    @(negedge clk);
    check("bp_count_full", 128'(count), 128'd2);
    check("bp_ready_full", 128'(in_if.ready), 128'd0);
    check("bp_head_a", out_if.data, SR_A);
    in_if.data = C;
    @(negedge clk);
    check("bp_hold_count", 128'(count), 128'd2);
    check("bp_hold_dout", out_if.data, SR_A);
    out_if.ready = 1'b1;
    @(negedge clk);
    check("bp_out_b", out_if.data, SR_B);
    check("bp_count_one", 128'(count), 128'd1);
    @(negedge clk);
    check("bp_out_c", out_if.data, SR_C);
    check("bp_pushpop_count", 128'(count), 128'd1);
    in_if.valid = 1'b0;
    @(negedge clk);
    check("bp_drain", 128'(count), 128'd0);
    // streaming: byte k of vector i is k + 16*i
    for (int i = 0; i < 16; i++) begin
      in_if.valid = 1'b1;
      in_if.data = A | {16{i[3:0], 4'h0}};
      @(negedge clk);
      check($sformatf("stream_dout_%0d", i), out_if.data, SR_A | {16{i[3:0], 4'h0}});
      check($sformatf("stream_count_%0d", i), 128'(count), 128'd1);
    end
    in_if.valid = 1'b0;
    @(negedge clk);
    check("stream_drain", 128'(out_if.valid), 128'd0);
    // reset while full
    out_if.ready = 1'b0; in_if.valid = 1'b1; in_if.data = B;
    @(negedge clk);
    @(negedge clk);
    in_if.valid = 1'b0;
    check("mid_full", 128'(count), 128'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_if.valid), 128'd0);
    check("mid_rst_count", 128'(count), 128'd0);
    check("mid_rst_dout", out_if.data, 128'd0);
    check("mid_rst_ready", 128'(in_if.ready), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", 128'(in_if.ready), 128'd1);
    check("mid_rel_valid", 128'(out_if.valid), 128'd0);
`ifdef SHIFTROW_INV_EN
    out_if.ready = 1'b1; in_if.valid = 1'b1; in_if.data = A; inv = 1'b0;
    @(negedge clk);
    y = out_if.data;
    check("inv_fwd", y, SR_A);
    in_if.data = y; inv = 1'b1;
    @(negedge clk);
    check("inv_roundtrip", out_if.data, A);
    in_if.data = A;
    @(negedge clk);
    check("inv_map", out_if.data, ISR_A);
    in_if.valid = 1'b0; inv = 1'b0;
    @(negedge clk);
`else
    y = '0;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
